// File: rtl/conv_pkg.sv
// Shared types and constants for the 512-to-1024 AXI4-Stream width up-converter.
// The optional statistics counters are enabled with the CONV_PACK_STATS_EN macro.
package conv_pkg;

  localparam int IN_W_DEF  = 512;
  localparam int OUT_W_DEF = 1024;

  // LO_EMPTY: no lower half held; LO_HELD: lower half waiting for its partner
  typedef enum logic {
    LO_EMPTY = 1'b0,
    LO_HELD  = 1'b1
  } state_e;

  // Byte-enable width for a given data width
  function automatic int keep_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/conv_axi512_to_axi1024.sv
// AXI4-Stream width up-converter: packs pairs of IN_DATA_W beats into one
// 2*IN_DATA_W beat (lower half = earlier beat). Odd-length packets end in a
// half-filled beat with upper keep zero. Output is registered.
// Optional macro CONV_PACK_STATS_EN adds the stat_pkts/stat_beats counters.
module conv_axi512_to_axi1024
  import conv_pkg::*;
#(
  parameter int IN_DATA_W = IN_W_DEF,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       in_ready,
  input  logic [IN_DATA_W-1:0]       in_data,
  input  logic [IN_DATA_W/8-1:0]     in_keep,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic                       out_ready,
  output logic [2*IN_DATA_W-1:0]     out_data,
  output logic [2*IN_DATA_W/8-1:0]   out_keep,
  output logic                       out_valid,
  output logic                       out_last
`ifdef CONV_PACK_STATS_EN
  ,
  output logic [CNT_W-1:0]           stat_pkts,
  output logic [CNT_W-1:0]           stat_beats
`endif
);

  localparam int IN_KEEP_W  = keep_w(IN_DATA_W);
  localparam int OUT_DATA_W = 2 * IN_DATA_W;
  localparam int OUT_KEEP_W = keep_w(OUT_DATA_W);

  // Handshake: a beat moves on a port when its valid and ready are both high in
  // the same cycle. in_ready depends only on out_ready and registered state
  // (never on in_valid), and out_* stay frozen while out_valid && !out_ready.

  state_e                  state_q, state_d;
  logic [IN_DATA_W-1:0]    hold_data_q, hold_data_d;
  logic [IN_KEEP_W-1:0]    hold_keep_q, hold_keep_d;
  logic [OUT_DATA_W-1:0]   out_data_q, out_data_d;
  logic [OUT_KEEP_W-1:0]   out_keep_q, out_keep_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;

  logic slot_free;
  logic in_xfer;
  logic out_xfer;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = slot_free;
  assign in_xfer   = in_valid && slot_free;
  assign out_xfer  = out_valid_q && out_ready;

  // Next-state and datapath: drain first, then a completing beat may reload
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (in_xfer) begin
      unique case (state_q)
        LO_EMPTY: begin
          if (in_last) begin
            // Single-beat tail or one-beat packet: upper half empty
            out_data_d  = {{IN_DATA_W{1'b0}}, in_data};
            out_keep_d  = {{IN_KEEP_W{1'b0}}, in_keep};
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
          end else begin
            hold_data_d = in_data;
            hold_keep_d = in_keep;
            state_d     = LO_HELD;
          end
        end
        LO_HELD: begin
          out_data_d  = {in_data, hold_data_q};
          out_keep_d  = {in_keep, hold_keep_q};
          out_valid_d = 1'b1;
          out_last_d  = in_last;
          state_d     = LO_EMPTY;
        end
        default: state_d = LO_EMPTY;
      endcase
    end
  end

  // State, holding and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LO_EMPTY;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

`ifdef CONV_PACK_STATS_EN
  logic [CNT_W-1:0] pkts_q, pkts_d;
  logic [CNT_W-1:0] beats_q, beats_d;

  // Counters advance on accepted output beats and wrap naturally
  always_comb begin
    pkts_d  = pkts_q;
    beats_d = beats_q;
    if (out_xfer) begin
      beats_d = beats_q + CNT_W'(1);
      if (out_last_q) begin
        pkts_d = pkts_q + CNT_W'(1);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_q  <= '0;
      beats_q <= '0;
    end else begin
      pkts_q  <= pkts_d;
      beats_q <= beats_d;
    end
  end

  assign stat_pkts  = pkts_q;
  assign stat_beats = beats_q;
`endif

endmodule

// File: tb/tb_conv_axi512_to_axi1024.sv
// Directed self-checking bench for conv_axi512_to_axi1024.
// Build with CONV_PACK_STATS_EN defined to also check the statistics counters.
module tb_conv_axi512_to_axi1024;
  import conv_pkg::*;

  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int ODW = 1024;
  localparam int OKW = 128;
  localparam int CW  = 32;
  localparam int EW  = ODW + OKW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [KW-1:0]   in_keep;
  logic            in_valid;
  logic            in_last;
  logic            out_ready;
  logic [ODW-1:0]  out_data;
  logic [OKW-1:0]  out_keep;
  logic            out_valid;
  logic            out_last;
`ifdef CONV_PACK_STATS_EN
  logic [CW-1:0]   stat_pkts;
  logic [CW-1:0]   stat_beats;
`endif

  always #5 clk = ~clk;

  conv_axi512_to_axi1024 #(.IN_DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_last  (out_last)
`ifdef CONV_PACK_STATS_EN
    ,
    .stat_pkts (stat_pkts),
    .stat_beats(stat_beats)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [EW-1:0] exp_q[$];
  int xfer_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [ODW-1:0] obs, input logic [ODW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      int w;
      w = 0;
      for (int i = 0; i < ODW / 64; i++) begin
        if (obs[i*64 +: 64] !== exp[i*64 +: 64]) begin
          w = i;
          break;
        end
      end
      errors++;
      $display("FAIL %s: word %0d got %h expected %h", tag, w, obs[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(n);
    return {16{w}};
  endfunction

  task automatic expect_beat(input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                             input logic [KW-1:0] khi, input logic [KW-1:0] klo,
                             input logic last);
    exp_q.push_back({last, khi, klo, hi, lo});
  endtask

  // Monitor: sample just after the falling edge, i.e. the handshake that the
  // next rising edge will complete
  always begin : monitor
    logic [EW-1:0] e;
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_out", ODW'(out_valid), ODW'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[ODW-1:0]);
        chk("out_keep", ODW'(out_keep), ODW'(e[ODW+OKW-1:ODW]));
        chk("out_last", ODW'(out_last), ODW'(e[EW-1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the transfer
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", ODW'(in_ready), ODW'(1));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", ODW'(exp_q.size()), ODW'(0));
    @(negedge clk);
  endtask

  localparam logic [KW-1:0] K_ALL = {KW{1'b1}};
  localparam logic [KW-1:0] K_ODD = 64'h00FF_F0F0_1234_5678;
  localparam logic [DW-1:0] Z     = '0;

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", ODW'(out_valid), ODW'(0));
    chk("rst_out_last", ODW'(out_last), ODW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_keep", ODW'(out_keep), ODW'(0));
    chk("rst_in_ready", ODW'(in_ready), ODW'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Even packet, back to back, no bubbles
    xfer_cyc.delete();
    expect_beat(mk(2), mk(1), K_ALL, K_ALL, 1'b0);
    expect_beat(mk(4), mk(3), K_ALL, K_ALL, 1'b1);
    send(mk(1), K_ALL, 1'b0);
    send(mk(2), K_ALL, 1'b0);
    send(mk(3), K_ALL, 1'b0);
    send(mk(4), K_ALL, 1'b1);
    wait_drain();
    chk("even_count", ODW'(xfer_cyc.size()), ODW'(2));
    if (xfer_cyc.size() >= 2) chk("even_gap", ODW'(xfer_cyc[1] - xfer_cyc[0]), ODW'(2));

    // Odd packet: tail beat half-filled
    expect_beat(mk(11), mk(10), K_ODD, K_ODD, 1'b0);
    expect_beat(Z, mk(12), '0, K_ODD, 1'b1);
    send(mk(10), K_ODD, 1'b0);
    send(mk(11), K_ODD, 1'b0);
    send(mk(12), K_ODD, 1'b1);
    wait_drain();

    // Single-beat packet, then realignment of the next packet
    expect_beat(Z, mk(20), '0, K_ALL, 1'b1);
    send(mk(20), K_ALL, 1'b1);
    #1;
    chk("single_latency", ODW'(out_valid), ODW'(1));
    expect_beat(mk(22), mk(21), K_ALL, K_ALL, 1'b1);
    send(mk(21), K_ALL, 1'b0);
    send(mk(22), K_ALL, 1'b1);
    wait_drain();

    // Backpressure: full output pending for 5 cycles
    out_ready = 1'b0;
    expect_beat(mk(31), mk(30), K_ALL, K_ALL, 1'b0);
    expect_beat(mk(33), mk(32), K_ALL, K_ALL, 1'b1);
    send(mk(30), K_ALL, 1'b0);
    send(mk(31), K_ALL, 1'b0);
    in_valid = 1'b1;
    in_data  = mk(32);
    in_keep  = K_ALL;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", ODW'(in_ready), ODW'(0));
      chk("bp_out_valid", ODW'(out_valid), ODW'(1));
      chk("bp_out_data", out_data, {mk(31), mk(30)});
      chk("bp_out_last", ODW'(out_last), ODW'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(mk(32), K_ALL, 1'b0);
    send(mk(33), K_ALL, 1'b1);
    wait_drain();

    // Reset while a lower half is held
    send(mk(40), K_ALL, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", ODW'(out_valid), ODW'(0));
    chk("rst_mid_in_ready", ODW'(in_ready), ODW'(1));
    expect_beat(mk(42), mk(41), K_ALL, K_ALL, 1'b1);
    send(mk(41), K_ALL, 1'b0);
    send(mk(42), K_ALL, 1'b1);
    wait_drain();

`ifdef CONV_PACK_STATS_EN
    // Packets emitted since the last reset: only the final 2-beat packet
    chk("stat_pkts", ODW'(stat_pkts), ODW'(1));
    chk("stat_beats", ODW'(stat_beats), ODW'(1));
    // Packets of 1, 2 and 3 beats
    expect_beat(Z, mk(50), '0, K_ALL, 1'b1);
    expect_beat(mk(52), mk(51), K_ALL, K_ALL, 1'b1);
    expect_beat(mk(54), mk(53), K_ALL, K_ALL, 1'b0);
    expect_beat(Z, mk(55), '0, K_ALL, 1'b1);
    send(mk(50), K_ALL, 1'b1);
    send(mk(51), K_ALL, 1'b0);
    send(mk(52), K_ALL, 1'b1);
    send(mk(53), K_ALL, 1'b0);
    send(mk(54), K_ALL, 1'b0);
    send(mk(55), K_ALL, 1'b1);
    wait_drain();
    chk("stat_pkts_end", ODW'(stat_pkts), ODW'(4));
    chk("stat_beats_end", ODW'(stat_beats), ODW'(5));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
